// File: rtl/spi_sub.sv
// spi_sub: SPI subordinate (CPOL=1, CPHA=1) decoding RW/address/data frames
// into single-cycle register read/write strobes, oversampled in the clk domain.
// Optional build macro SPI_SUB_AUTOINC_EN: keeps streaming data words at
// auto-incremented addresses while cs_n stays low.
module spi_sub #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAX_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RW,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sclkSync_q;
  logic [SYNC_STAGES-1:0] csSync_q;
  logic [SYNC_STAGES-1:0] mosiSync_q;
  logic [SYNC_STAGES-1:0] syncValid_q;
  logic                   sclkPrev_q;
  logic                   csPrev_q;
  logic                   armed_q;

  state_t                 state_q;
  logic [CNT_W-1:0]       bitCnt_q;
  logic                   rw_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-2:0]  rxShift_q;
  logic [DATA_WIDTH-1:0]  txShift_q;
  logic                   loadTx_q;
  logic                   miso_q;
  logic                   misoOe_q;
  logic                   wrEn_q;
  logic [ADDR_WIDTH-1:0]  wrAddr_q;
  logic [DATA_WIDTH-1:0]  wrData_q;
  logic                   rdEn_q;
  logic [ADDR_WIDTH-1:0]  rdAddr_q;
  logic                   busy_q;
  logic                   frameErr_q;
`ifdef SPI_SUB_AUTOINC_EN
  logic                   wordDone_q;
`endif

  logic                   sclkS;
  logic                   csS;
  logic                   mosiS;
  logic                   sclkRise;
  logic                   sclkFall;
  logic                   csRise;
  logic                   csFall;
  logic                   atBoundary;
  logic                   abortNow;
  logic [ADDR_WIDTH-1:0]  nextAddr_d;
  logic [DATA_WIDTH-1:0]  rxWord_d;

  assign sclkS = sclkSync_q[SYNC_STAGES-1];
  assign csS   = csSync_q[SYNC_STAGES-1];
  assign mosiS = mosiSync_q[SYNC_STAGES-1];

  // sclk edges only count while selected; a cs_n rise (csS=1) masks any coincident sclk edge
  assign sclkRise = sclkS & ~sclkPrev_q & ~csS;
  assign sclkFall = ~sclkS & sclkPrev_q & ~csS;
  assign csRise   = csS & ~csPrev_q;
  assign csFall   = ~csS & csPrev_q;

  assign nextAddr_d = {addr_q[ADDR_WIDTH-2:0], mosiS};
  assign rxWord_d   = {rxShift_q, mosiS};

`ifdef SPI_SUB_AUTOINC_EN
  assign atBoundary = wordDone_q && (bitCnt_q == CNT_W'(DATA_WIDTH - 1));
`else
  assign atBoundary = 1'b0;
`endif

  assign abortNow = csRise && ((state_q == S_RW) || (state_q == S_ADDR) ||
                               ((state_q == S_DATA) && !atBoundary));

  // Input synchronizers; syncValid_q marks when the chains hold real pin samples after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclkSync_q  <= '1;
      csSync_q    <= '1;
      mosiSync_q  <= '0;
      syncValid_q <= '0;
    end else begin
      sclkSync_q  <= {sclkSync_q[SYNC_STAGES-2:0], sclk};
      csSync_q    <= {csSync_q[SYNC_STAGES-2:0], cs_n};
      mosiSync_q  <= {mosiSync_q[SYNC_STAGES-2:0], mosi};
      syncValid_q <= {syncValid_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Edge-detect history, plus arming so a frame cut by reset is ignored until cs_n is seen high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclkPrev_q <= 1'b1;
      csPrev_q   <= 1'b1;
      armed_q    <= 1'b0;
    end else begin
      sclkPrev_q <= sclkS;
      csPrev_q   <= csS;
      if (syncValid_q[SYNC_STAGES-1] && csS) begin
        armed_q <= 1'b1;
      end
    end
  end

  // Frame state machine with registered strobes, shift registers and pad outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bitCnt_q   <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      rxShift_q  <= '0;
      txShift_q  <= '0;
      loadTx_q   <= 1'b0;
      miso_q     <= 1'b0;
      misoOe_q   <= 1'b0;
      wrEn_q     <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
      rdEn_q     <= 1'b0;
      rdAddr_q   <= '0;
      busy_q     <= 1'b0;
      frameErr_q <= 1'b0;
`ifdef SPI_SUB_AUTOINC_EN
      wordDone_q <= 1'b0;
`endif
    end else begin
      wrEn_q     <= 1'b0;
      rdEn_q     <= 1'b0;
      frameErr_q <= 1'b0;
      misoOe_q   <= ~csS;
      loadTx_q   <= rdEn_q;
      if (loadTx_q) begin
        txShift_q <= rd_data;
      end

      if (abortNow) begin
        state_q    <= S_IDLE;
        busy_q     <= 1'b0;
        frameErr_q <= 1'b1;
        miso_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            miso_q <= 1'b0;
            if (csFall && armed_q) begin
              state_q  <= S_RW;
              bitCnt_q <= CNT_W'(ADDR_WIDTH - 1);
              busy_q   <= 1'b1;
              rw_q     <= 1'b0;
`ifdef SPI_SUB_AUTOINC_EN
              wordDone_q <= 1'b0;
`endif
            end
          end

          S_RW: begin
            if (sclkRise) begin
              rw_q    <= mosiS;
              state_q <= S_ADDR;
            end
          end

          S_ADDR: begin
            if (sclkRise) begin
              addr_q <= nextAddr_d;
              if (bitCnt_q == '0) begin
                bitCnt_q <= CNT_W'(DATA_WIDTH - 1);
                state_q  <= S_DATA;
                if (!rw_q) begin
                  rdEn_q   <= 1'b1;
                  rdAddr_q <= nextAddr_d;
                end
              end else begin
                bitCnt_q <= bitCnt_q - CNT_W'(1);
              end
            end
          end

          S_DATA: begin
            if (csRise) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              miso_q  <= 1'b0;
            end else begin
              if (sclkFall && !rw_q) begin
                miso_q    <= txShift_q[DATA_WIDTH-1];
                txShift_q <= txShift_q << 1;
              end
              if (sclkRise) begin
                rxShift_q <= rxWord_d[DATA_WIDTH-2:0];
`ifdef SPI_SUB_AUTOINC_EN
                wordDone_q <= 1'b0;
`endif
                if (bitCnt_q == '0) begin
                  if (rw_q) begin
                    wrEn_q   <= 1'b1;
                    wrAddr_q <= addr_q;
                    wrData_q <= rxWord_d;
                  end
`ifdef SPI_SUB_AUTOINC_EN
                  bitCnt_q   <= CNT_W'(DATA_WIDTH - 1);
                  addr_q     <= addr_q + ADDR_WIDTH'(1);
                  wordDone_q <= 1'b1;
                  if (!rw_q) begin
                    rdEn_q   <= 1'b1;
                    rdAddr_q <= addr_q + ADDR_WIDTH'(1);
                  end
`else
                  state_q <= S_DONE;
                  miso_q  <= 1'b0;
`endif
                end else begin
                  bitCnt_q <= bitCnt_q - CNT_W'(1);
                end
              end
            end
          end

          S_DONE: begin
            miso_q <= 1'b0;
            if (csRise) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end

          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            miso_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = misoOe_q;
  assign wr_en     = wrEn_q;
  assign wr_addr   = wrAddr_q;
  assign wr_data   = wrData_q;
  assign rd_en     = rdEn_q;
  assign rd_addr   = rdAddr_q;
  assign busy      = busy_q;
  assign frame_err = frameErr_q;

endmodule
